// File: rtl/core_pkg.sv
// Shared writeback types: architectural widths, the held-entry record and the source id.
// No logic of its own; latency and backpressure belong to the modules that import it.
// Imported by the writeback holding slot and arbiter.
package core_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   typedef enum logic {
      SRC_LSU = 1'b0,
      SRC_ALU = 1'b1
   } wb_src_e;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register in front of the writeback arbiter.
// Latency: an accepted result is visible as hold_vld from the next cycle.
// Backpressure: in_rdy drops while full and not granted, and whenever clear is high.
module wb_hold_slot
   import core_pkg::*;
#(
   parameter int WIDTH  = XLEN,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [WIDTH-1:0]  in_dat,
   input  logic              grant,
   input  logic              clear,
   output logic              hold_vld,
   output logic [ADDR_W-1:0] hold_rd,
   output logic [WIDTH-1:0]  hold_dat
);

   // A granted entry leaves at this edge, so the slot can refill in the same cycle.
   assign in_rdy = !clear && (!hold_vld || grant);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_vld <= 1'b0;
         hold_rd  <= '0;
         hold_dat <= '0;
      end else if (clear) begin
         hold_vld <= 1'b0;
      end else if (in_vld && in_rdy) begin
         hold_vld <= 1'b1;
         hold_rd  <= in_rd;
         hold_dat <= in_dat;
      end else if (grant) begin
         hold_vld <= 1'b0;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU and LSU results into one registered regfile write, plus decode bypass.
// Latency: handshake at edge N, grant in cycle N+1, w_en in cycle N+2; forwarding is combinational.
// Backpressure: each source stalls only while its held entry waits for a grant, and during flush.
module wb_arbiter
   import core_pkg::*;
#(
   parameter int WIDTH  = XLEN,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [WIDTH-1:0]  alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [WIDTH-1:0]  lsu_data,
   input  logic              flush,
   output logic              w_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  w_data,
   input  logic [ADDR_W-1:0] fwd_addr_a,
   input  logic [ADDR_W-1:0] fwd_addr_b,
   output logic              fwd_hit_a,
   output logic [WIDTH-1:0]  fwd_data_a,
   output logic              fwd_hit_b,
   output logic [WIDTH-1:0]  fwd_data_b
);

   logic              alu_hold_vld, lsu_hold_vld;
   logic [ADDR_W-1:0] alu_hold_rd, lsu_hold_rd;
   logic [WIDTH-1:0]  alu_hold_dat, lsu_hold_dat;
   logic              gnt_alu, gnt_lsu, alu_acc, lsu_acc, contested;
   wb_src_e           gnt_src, rr_ptr, older_src;
   wb_entry_t         sel;

   wb_hold_slot #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_alu_slot (
      .clk      (clk),
      .reset    (reset),
      .in_vld   (alu_valid),
      .in_rdy   (alu_ready),
      .in_rd    (alu_rd),
      .in_dat   (alu_data),
      .grant    (gnt_alu),
      .clear    (flush),
      .hold_vld (alu_hold_vld),
      .hold_rd  (alu_hold_rd),
      .hold_dat (alu_hold_dat)
   );

   wb_hold_slot #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_lsu_slot (
      .clk      (clk),
      .reset    (reset),
      .in_vld   (lsu_valid),
      .in_rdy   (lsu_ready),
      .in_rd    (lsu_rd),
      .in_dat   (lsu_data),
      .grant    (gnt_lsu),
      .clear    (flush),
      .hold_vld (lsu_hold_vld),
      .hold_rd  (lsu_hold_rd),
      .hold_dat (lsu_hold_dat)
   );

   assign contested = alu_hold_vld && lsu_hold_vld;
   assign alu_acc   = alu_valid && alu_ready;
   assign lsu_acc   = lsu_valid && lsu_ready;

   // Same-register conflicts must commit in acceptance order, so age overrides round-robin.
   always_comb begin
      gnt_src = SRC_LSU;
      if (contested) begin
         if (alu_hold_rd == lsu_hold_rd && lsu_hold_rd != ZERO_REG)
            gnt_src = older_src;
         else
            gnt_src = rr_ptr;
      end else if (alu_hold_vld) begin
         gnt_src = SRC_ALU;
      end
   end

   assign gnt_alu = alu_hold_vld && (gnt_src == SRC_ALU);
   assign gnt_lsu = lsu_hold_vld && (gnt_src == SRC_LSU);

   always_comb begin
      sel.valid = gnt_alu || gnt_lsu;
      sel.rd    = (gnt_src == SRC_ALU) ? alu_hold_rd  : lsu_hold_rd;
      sel.data  = (gnt_src == SRC_ALU) ? alu_hold_dat : lsu_hold_dat;
   end

   // A fresh ALU entry is never older than whatever LSU entry survives this edge, and vice versa.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= SRC_LSU;
         older_src <= SRC_LSU;
      end else if (!flush) begin
         if (contested)
            rr_ptr <= (rr_ptr == SRC_LSU) ? SRC_ALU : SRC_LSU;
         if (alu_acc)
            older_src <= SRC_LSU;
         else if (lsu_acc)
            older_src <= SRC_ALU;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_en    <= 1'b0;
         rd_addr <= '0;
         w_data  <= '0;
      end else if (flush) begin
         w_en <= 1'b0;
      end else begin
         w_en <= sel.valid && (sel.rd != ZERO_REG);
         if (sel.valid) begin
            rd_addr <= sel.rd;
            w_data  <= sel.data;
         end
      end
   end

   assign fwd_hit_a  = w_en && (rd_addr == fwd_addr_a) && (fwd_addr_a != ZERO_REG);
   assign fwd_hit_b  = w_en && (rd_addr == fwd_addr_b) && (fwd_addr_b != ZERO_REG);
   assign fwd_data_a = fwd_hit_a ? w_data : '0;
   assign fwd_data_b = fwd_hit_b ? w_data : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table of per-cycle inputs and expected outputs for wb_arbiter, plus an async-reset sequence.
module tb_wb_arbiter;

   logic        clk;
   logic        reset;
   logic        alu_valid, alu_ready, lsu_valid, lsu_ready, flush;
   logic [4:0]  alu_rd, lsu_rd, rd_addr, fwd_addr_a, fwd_addr_b;
   logic [31:0] alu_data, lsu_data, w_data, fwd_data_a, fwd_data_b;
   logic        w_en, fwd_hit_a, fwd_hit_b;

   int ncmp;
   int nfail;

   typedef struct {
      logic        av;
      logic [4:0]  ar;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  lr;
      logic [31:0] ld;
      logic        fl;
      logic [4:0]  fa;
      logic [4:0]  fb;
      logic        e_wen;
      logic [4:0]  e_rd;
      logic [31:0] e_dat;
      logic        e_ardy;
      logic        e_lrdy;
      logic        chk_wr;
   } vec_t;

   vec_t vecs[$];

   wb_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .flush      (flush),
      .w_en       (w_en),
      .rd_addr    (rd_addr),
      .w_data     (w_data),
      .fwd_addr_a (fwd_addr_a),
      .fwd_addr_b (fwd_addr_b),
      .fwd_hit_a  (fwd_hit_a),
      .fwd_data_a (fwd_data_a),
      .fwd_hit_b  (fwd_hit_b),
      .fwd_data_b (fwd_data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic fl, input logic [4:0] fa, input logic [4:0] fb,
                      input logic e_wen, input logic [4:0] e_rd, input logic [31:0] e_dat,
                      input logic e_ardy, input logic e_lrdy, input logic chk_wr);
      vec_t v;
      v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld;
      v.fl = fl; v.fa = fa; v.fb = fb;
      v.e_wen = e_wen; v.e_rd = e_rd; v.e_dat = e_dat;
      v.e_ardy = e_ardy; v.e_lrdy = e_lrdy; v.chk_wr = chk_wr;
      vecs.push_back(v);
   endtask

   initial begin
      logic        exp_ha, exp_hb;
      logic [31:0] exp_da, exp_db;
      ncmp  = 0;
      nfail = 0;
      reset = 1'b0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      flush = 1'b0; fwd_addr_a = '0; fwd_addr_b = '0;

      //   av ar  ad    lv lr  ld    fl fa  fb   wen rd  dat   ardy lrdy chk
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   0,  0,  0,    1, 1, 1);  // 0 idle after reset
      add(1, 5,  400,  0, 0,  0,    0, 0,  0,   0,  0,  0,    1, 1, 1);  // 1 single ALU write
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   0,  0,  0,    1, 1, 1);  // 2
      add(0, 0,  0,    0, 0,  0,    0, 5,  6,   1,  5,  400,  1, 1, 1);  // 3 commit + forward
      add(0, 0,  0,    0, 0,  0,    0, 5,  0,   0,  5,  400,  1, 1, 1);  // 4 one cycle only
      add(1, 1,  1,    1, 2,  2,    0, 0,  0,   0,  5,  400,  1, 1, 1);  // 5 pair, ptr=LSU
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   0,  5,  400,  0, 1, 1);  // 6
      add(0, 0,  0,    0, 0,  0,    0, 2,  1,   1,  2,  2,    1, 1, 1);  // 7
      add(0, 0,  0,    0, 0,  0,    0, 2,  1,   1,  1,  1,    1, 1, 1);  // 8
      add(1, 3,  3,    1, 4,  4,    0, 0,  0,   0,  1,  1,    1, 1, 1);  // 9 pair, ptr=ALU
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   0,  1,  1,    1, 0, 1);  // 10
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   1,  3,  3,    1, 1, 1);  // 11
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   1,  4,  4,    1, 1, 1);  // 12
      add(1, 7,  70,   1, 8,  80,   0, 0,  0,   0,  4,  4,    1, 1, 1);  // 13 pair, ptr=LSU
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   0,  4,  4,    0, 1, 1);  // 14
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   1,  8,  80,   1, 1, 1);  // 15
      add(1, 31, 31,   1, 31, 7,    0, 0,  0,   1,  7,  70,   1, 1, 1);  // 16 same rd, ptr=ALU
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   0,  7,  70,   0, 1, 1);  // 17 older LSU wins
      add(0, 0,  0,    0, 0,  0,    0, 31, 0,   1,  31, 7,    1, 1, 1);  // 18
      add(0, 0,  0,    0, 0,  0,    0, 31, 0,   1,  31, 31,   1, 1, 1);  // 19
      add(0, 0,  0,    1, 31, 7,    0, 0,  0,   0,  31, 31,   1, 1, 1);  // 20 LSU then ALU
      add(1, 31, 31,   0, 0,  0,    0, 0,  0,   0,  31, 31,   1, 1, 1);  // 21
      add(0, 0,  0,    0, 0,  0,    0, 0,  31,  1,  31, 7,    1, 1, 1);  // 22
      add(0, 0,  0,    0, 0,  0,    0, 0,  31,  1,  31, 31,   1, 1, 1);  // 23
      add(1, 0,  400,  0, 0,  0,    0, 0,  0,   0,  31, 31,   1, 1, 1);  // 24 rd=0
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   0,  31, 31,   1, 1, 1);  // 25
      add(0, 0,  0,    0, 0,  0,    0, 0,  31,  0,  0,  0,    1, 1, 0);  // 26 no write
      add(1, 10, 100,  1, 11, 110,  0, 0,  0,   0,  0,  0,    1, 1, 0);  // 27 backpressure
      add(1, 12, 120,  0, 0,  0,    0, 0,  0,   0,  0,  0,    0, 1, 0);  // 28 ALU stalled
      add(1, 12, 120,  0, 0,  0,    0, 0,  0,   1,  11, 110,  1, 1, 1);  // 29
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   1,  10, 100,  1, 1, 1);  // 30
      add(0, 0,  0,    0, 0,  0,    0, 12, 0,   1,  12, 120,  1, 1, 1);  // 31
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   0,  12, 120,  1, 1, 1);  // 32 no duplicate
      add(0, 0,  0,    1, 20, 200,  0, 0,  0,   0,  12, 120,  1, 1, 1);  // 33 flush setup
      add(1, 13, 130,  1, 14, 140,  0, 0,  0,   0,  12, 120,  1, 1, 1);  // 34
      add(1, 15, 150,  0, 0,  0,    1, 20, 0,   1,  20, 200,  0, 0, 1);  // 35 flush
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   0,  20, 200,  1, 1, 1);  // 36
      add(0, 0,  0,    0, 0,  0,    0, 0,  0,   0,  20, 200,  1, 1, 1);  // 37
      add(1, 21, 210,  0, 0,  0,    0, 0,  0,   0,  20, 200,  1, 1, 1);  // 38
      add(1, 22, 220,  0, 0,  0,    0, 0,  0,   0,  20, 200,  1, 1, 1);  // 39
      add(0, 0,  0,    0, 0,  0,    0, 21, 0,   1,  21, 210,  1, 1, 1);  // 40 reset lands here

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("in_reset w_en", 32'(w_en), 32'd0);
      check("in_reset rd_addr", 32'(rd_addr), 32'd0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         alu_valid = vecs[i].av; alu_rd = vecs[i].ar; alu_data = vecs[i].ad;
         lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lr; lsu_data = vecs[i].ld;
         flush = vecs[i].fl; fwd_addr_a = vecs[i].fa; fwd_addr_b = vecs[i].fb;
         #1;
         exp_ha = vecs[i].e_wen && vecs[i].e_rd == vecs[i].fa && vecs[i].fa != 5'd0;
         exp_hb = vecs[i].e_wen && vecs[i].e_rd == vecs[i].fb && vecs[i].fb != 5'd0;
         exp_da = exp_ha ? vecs[i].e_dat : 32'd0;
         exp_db = exp_hb ? vecs[i].e_dat : 32'd0;
         check($sformatf("r%0d w_en", i), 32'(w_en), 32'(vecs[i].e_wen));
         if (vecs[i].chk_wr) begin
            check($sformatf("r%0d rd_addr", i), 32'(rd_addr), 32'(vecs[i].e_rd));
            check($sformatf("r%0d w_data", i), w_data, vecs[i].e_dat);
         end
         check($sformatf("r%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ardy));
         check($sformatf("r%0d lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_lrdy));
         check($sformatf("r%0d fwd_hit_a", i), 32'(fwd_hit_a), 32'(exp_ha));
         check($sformatf("r%0d fwd_data_a", i), fwd_data_a, exp_da);
         check($sformatf("r%0d fwd_hit_b", i), 32'(fwd_hit_b), 32'(exp_hb));
         check($sformatf("r%0d fwd_data_b", i), fwd_data_b, exp_db);
      end

      // Mid-commit async reset: outputs clear without a clock edge, held ALU entry is lost.
      #2;
      reset = 1'b0;
      #1;
      check("async_rst w_en", 32'(w_en), 32'd0);
      check("async_rst rd_addr", 32'(rd_addr), 32'd0);
      check("async_rst w_data", w_data, 32'd0);
      check("async_rst fwd_hit_a", 32'(fwd_hit_a), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      fwd_addr_a = '0;
      #1;
      check("post_rst alu_ready", 32'(alu_ready), 32'd1);
      check("post_rst lsu_ready", 32'(lsu_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("post_rst c%0d w_en", k), 32'(w_en), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage that sits directly upstream of the register file write port (`w_en`, `rd_addr`, `w_data`).
- Accepts results from two producers: the ALU and the load/store unit. Each producer has a valid/ready handshake and a one-entry holding register.
- Arbitrates between them round-robin, honouring age order on same-register conflicts, and issues one registered write per cycle.
- Also exposes a same-cycle bypass of the write being committed, so decode reads never see stale regfile data.

Parameters:
- WIDTH, 32, data width of results and register file.
- ADDR_W, 5, register address width (32 architectural registers; register 0 hardwired zero).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU holding register can accept.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- lsu_valid  in  1  load result valid.
- lsu_ready  out  1  LSU holding register can accept.
- lsu_rd  in  ADDR_W  load destination register.
- lsu_data  in  WIDTH  load result.
- flush  in  1  drop all held, uncommitted results.
- w_en  out  1  regfile write enable (registered).
- rd_addr  out  ADDR_W  regfile write address (registered).
- w_data  out  WIDTH  regfile write data (registered).
- fwd_addr_a  in  ADDR_W  decode read address A.
- fwd_addr_b  in  ADDR_W  decode read address B.
- fwd_hit_a  out  1  w_en && rd_addr==fwd_addr_a && fwd_addr_a!=0 (combinational).
- fwd_data_a  out  WIDTH  w_data when fwd_hit_a, else 0.
- fwd_hit_b  out  1  as A, for port B.
- fwd_data_b  out  WIDTH  as A, for port B.

Behaviour:
- Reset (reset==0, async):
  - Both holding registers empty; age flag and round-robin pointer cleared (pointer favours LSU first).
  - w_en=0, rd_addr=0, w_data=0; alu_ready=lsu_ready=1 once reset deasserts.
- Holding registers:
  - Each source has hold_valid, hold_rd, hold_data.
  - src_ready = !hold_valid || granted_this_cycle. This is a combinational dependency on the grant, not on the input valid.
  - A transfer occurs at the edge when src_valid && src_ready; the entry is then held from the next cycle.
- Age tracking:
  - A 1-bit flag records which held entry was accepted earlier.
  - If both are accepted on the same edge, the LSU entry is older.
- Arbitration, each cycle, over held entries only:
  - One held entry: grant it.
  - Both held, same nonzero rd: grant the older one, regardless of round-robin.
  - Both held, different rd: grant the source the pointer selects. The pointer flips to the other source after every contested grant.
- Commit:
  - The granted entry loads the output register at the next edge.
  - w_en=1 for exactly that cycle; rd_addr and w_data are taken from the entry.
  - If no grant, w_en=0. rd_addr and w_data hold their previous values.
- Register 0: an entry with rd==0 is granted and consumed normally, but commits with w_en=0 and is never forwarded.
- Latency: input handshake edge N, grant in cycle N+1, w_en high in cycle N+2. With both sources streaming, sustained throughput is 1 write per cycle.
- Flush:
  - At the edge with flush=1, both holding registers clear and any grant in that cycle is cancelled (no commit next cycle).
  - Inputs presented during flush are not accepted: alu_ready=lsu_ready=0 while flush=1.
  - The output register already holding a write completes normally.
- Reset mid-operation: all state clears immediately. Held results are lost and no spurious w_en is produced.
- Forwarding is purely combinational from the output register and the fwd addresses; it has no state.

Decomposition:
- Shared package `core_pkg`:
  - XLEN=32, REG_ADDR_W=5, ZERO_REG=0.
  - typedef `wb_entry_t` {valid, rd, data}.
  - enum `wb_src_e` {SRC_LSU, SRC_ALU}.
- Sub-module `wb_hold_slot`: one holding register with valid/ready and grant/clear inputs. It is instantiated twice; the arbitration, age and output logic stay in `wb_arbiter`.

Test Plan:
- Reset then idle: reset low 2 cycles, then high → w_en=0, rd_addr=0, w_data=0, both ready=1, fwd_hit_a/b=0.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=400 for one edge → w_en=1, rd_addr=5, w_data=400 exactly 2 cycles later, for one cycle. With fwd_addr_a=5 in that cycle → fwd_hit_a=1, fwd_data_a=400.
- Simultaneous different rd: ALU rd=1/data=1 and LSU rd=2/data=2 on the same edge → LSU commits first (rd=2), then ALU (rd=1) the next cycle. A repeat pair then commits ALU first (pointer flipped).
- Same-rd ordering: LSU rd=31/data=7 accepted one edge before ALU rd=31/data=31 → commits 7 then 31. Final regfile x31=31.
- Register 0 and backpressure: ALU rd=0/data=400 → consumed, w_en stays 0, fwd_hit=0. ALU valid held high with LSU contending → alu_ready=0 while its slot waits, and no result is lost or duplicated.
- Flush and async reset: hold both slots, assert flush → no w_en follows, and the ready signals return to 1. Assert reset mid-commit → w_en=0 immediately (asynchronously).
